load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised data-memory interface for the RISC-V core; sits between the dataflow (address from ALU, store data from rs2) and the data memory.
- Replaces purely combinational load extension with a handshaked, multi-cycle access.
- Supports XLEN 32 or 64, byte-lane alignment, sign/zero extension and misalignment/illegal-width detection.
- Tolerates a variable-latency memory via a valid/ack protocol.

Parameters:
- XLEN, 64, data/address width; legal values 32 and 64.
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_address  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  XLEN  load result, extended.
- resp_misaligned  out  1  address not naturally aligned.
- resp_error  out  1  illegal funct3 or bus timeout.
- mem_rd_en  out  1  memory read request.
- mem_wr_en  out  1  memory write request.
- mem_address  out  XLEN  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_byte_enable  out  XLEN/8  active byte lanes.
- mem_rdata  in  XLEN  full-word read data.
- mem_ack  in  1  access complete; rdata valid this cycle.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except req_ready=1; watchdog counter cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch write, funct3, byte offset and request data.
  - Legal and aligned request: go to BUSY. mem_rd_en or mem_wr_en, mem_address, mem_wdata and mem_byte_enable are registered and appear the next cycle.
  - Misaligned or illegal request: go to DONE with no memory access.
- BUSY:
  - req_ready=0; mem_* outputs held stable.
  - On mem_ack: capture the extended load result, drop the enables in the same registered update, go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata=0 for stores and faults.
  - A new request is accepted no earlier than the cycle after DONE.
- Minimum latency: accept in cycle 0, mem enable in cycle 1, ack in cycle 1, resp_valid in cycle 2.
- mem_ack outside BUSY is ignored. Response fields hold their last value until the next DONE.
- Widths:
  - funct3[1:0]: 0=byte, 1=half, 2=word, 3=double.
  - funct3[2]=1 means unsigned. Unsigned is valid for loads only, and LWU only when XLEN=64.
  - Double is legal only when XLEN=64. Stores with funct3[2]=1 are illegal.
- Alignment: misaligned when address mod size ≠ 0.
- Lanes:
  - offset = address[log2(XLEN/8)-1:0].
  - mem_byte_enable = size mask << offset.
  - mem_wdata = req_wdata << 8*offset.
  - Load: (mem_rdata >> 8*offset), truncated to size, then sign- or zero-extended to XLEN.
- Reset asserted in BUSY or DONE: immediate return to IDLE; any pending ack is discarded.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter counts cycles in BUSY.
  - If no ack arrives by count TIMEOUT_CYCLES, enables drop and the FSM goes to DONE with resp_error=1 and resp_rdata=0.
  - The counter clears on entry to BUSY.
- Undefined: no counter; BUSY waits indefinitely for mem_ack.

Decomposition:
- Shared package/header holds:
  - funct3 width constants: LSU_BYTE, LSU_HALF, LSU_WORD, LSU_DOUBLE, LSU_UNSIGNED_BIT.
  - FSM state encodings: LSU_IDLE, LSU_BUSY, LSU_DONE.
- One combinational sub-module, lsu_load_extend (params XLEN; inputs rdata, offset, funct3; output extended data), reused by future cached paths.

Test Plan:
1. XLEN=64, LB at 0x1003, mem_rdata=0x0000_0000_8000_0000 -> mem_address=0x1000, mem_byte_enable=8'b0000_1000, resp_rdata=0xFFFF_FFFF_FFFF_FF80; same request as LBU -> 0x0000_0000_0000_0080.
2. SH at 0x2006, req_wdata=0x1234_ABCD -> mem_wr_en=1, mem_byte_enable=8'b1100_0000, mem_wdata[63:48]=0xABCD, resp_valid 1 cycle after ack, resp_rdata=0.
3. LW at 0x3002 -> mem_rd_en never asserted; resp_valid=1 and resp_misaligned=1 one cycle after acceptance. XLEN=32, LD at 0x0 -> resp_error=1.
4. LD at 0x4000, mem_ack delayed 5 cycles -> mem_rd_en and mem_address stable 5 cycles, req_ready=0 throughout, resp_valid exactly one cycle, cycle after ack.
5. reset=0 during BUSY, late mem_ack after reset=1 -> all outputs 0, req_ready=1, no resp_valid.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> enables drop after 16 cycles in BUSY, resp_valid=1, resp_error=1, resp_rdata=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 width codes and FSM states.
// Imported by load_store_unit and lsu_load_extend.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_BYTE   = 2'd0;
  localparam logic [1:0] LSU_HALF   = 2'd1;
  localparam logic [1:0] LSU_WORD   = 2'd2;
  localparam logic [1:0] LSU_DOUBLE = 2'd3;
  localparam int LSU_UNSIGNED_BIT   = 2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_extend.sv
// Lane-selects a full memory word and sign/zero extends the loaded value.
// Purely combinational; shared by uncached and future cached load paths.
module lsu_load_extend
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            data
);

  logic [XLEN-1:0] sh;
  logic            uns;

  always_comb begin
    sh   = rdata >> {offset, 3'b000};
    uns  = funct3[LSU_UNSIGNED_BIT];
    data = sh;
    unique case (funct3[1:0])
      LSU_BYTE:
        data = uns ? XLEN'(sh[7:0])
                   : XLEN'($signed(sh[7:0]));
      LSU_HALF:
        data = uns ? XLEN'(sh[15:0])
                   : XLEN'($signed(sh[15:0]));
      LSU_WORD:
        data = uns ? XLEN'(sh[31:0])
                   : XLEN'($signed(sh[31:0]));
      LSU_DOUBLE:
        data = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked data-memory interface: alignment, lanes, extension, fault checks.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_address,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_error,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [XLEN-1:0]   mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_byte_enable,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack
);

  localparam int  NB   = XLEN / 8;
  localparam int  OFFW = $clog2(NB);
  localparam bit  IS64 = (XLEN == 64);

  lsu_state_e state, state_nxt;

  logic [1:0]      size;
  logic            uns;
  logic            legal;
  logic            misal;
  logic            ok;
  logic [2:0]      amask;
  logic [NB-1:0]   smask;
  logic [OFFW-1:0] offset;

  logic            r_write;
  logic [2:0]      r_funct3;
  logic [OFFW-1:0] r_offset;
  logic [XLEN-1:0] ext_data;
  logic            timeout;

  always_comb begin
    size   = req_funct3[1:0];
    uns    = req_funct3[LSU_UNSIGNED_BIT];
    offset = req_address[OFFW-1:0];
    amask  = 3'((4'd1 << size) - 4'd1);
    misal  = |(req_address[2:0] & amask);
    if (req_write)
      legal = !uns && (size != LSU_DOUBLE || IS64);
    else if (uns)
      legal = (size == LSU_BYTE) || (size == LSU_HALF) ||
              (size == LSU_WORD && IS64);
    else
      legal = (size != LSU_DOUBLE) || IS64;
    ok = legal && !misal;
    unique case (size)
      LSU_BYTE:   smask = NB'(8'h01);
      LSU_HALF:   smask = NB'(8'h03);
      LSU_WORD:   smask = NB'(8'h0F);
      LSU_DOUBLE: smask = NB'(8'hFF);
    endcase
  end

  lsu_load_extend #(.XLEN(XLEN)) u_ext (
    .rdata  (mem_rdata),
    .offset (r_offset),
    .funct3 (r_funct3),
    .data   (ext_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [TW-1:0] wd_cnt;

  // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wd_cnt <= '0;
    else if (state != LSU_BUSY)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + TW'(1);
  end

  assign timeout = (state == LSU_BUSY) && !mem_ack &&
                   (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= LSU_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LSU_IDLE:
        if (req_valid)
          state_nxt = ok ? LSU_BUSY : LSU_DONE;
      LSU_BUSY:
        if (mem_ack || timeout)
          state_nxt = LSU_DONE;
      LSU_DONE:
        state_nxt = LSU_IDLE;
      default:
        state_nxt = LSU_IDLE;
    endcase
  end

  assign req_ready  = (state == LSU_IDLE);
  assign resp_valid = (state == LSU_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write         <= 1'b0;
      r_funct3        <= '0;
      r_offset        <= '0;
      mem_rd_en       <= 1'b0;
      mem_wr_en       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_error      <= 1'b0;
    end else begin
      unique case (state)
        LSU_IDLE:
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_offset <= offset;
            if (ok) begin
              mem_rd_en       <= !req_write;
              mem_wr_en       <= req_write;
              mem_address     <= {req_address[XLEN-1:OFFW], OFFW'(0)};
              mem_wdata       <= req_wdata << {offset, 3'b000};
              mem_byte_enable <= smask << offset;
            end else begin
              resp_rdata      <= '0;
              resp_misaligned <= misal;
              resp_error      <= !legal;
            end
          end
        LSU_BUSY:
          if (mem_ack || timeout) begin
            mem_rd_en       <= 1'b0;
            mem_wr_en       <= 1'b0;
            resp_rdata      <= (r_write || !mem_ack) ? '0 : ext_data;
            resp_misaligned <= 1'b0;
            resp_error      <= !mem_ack;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=64 and XLEN=32 instances).
// Watchdog scenario runs only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_address = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_error;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_byte_enable;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic        s_req_write = 1'b0;
  logic [2:0]  s_req_funct3 = '0;
  logic [31:0] s_req_address = '0;
  logic [31:0] s_req_wdata = '0;
  logic        s_resp_valid;
  logic [31:0] s_resp_rdata;
  logic        s_resp_misaligned;
  logic        s_resp_error;
  logic        s_mem_rd_en;
  logic        s_mem_wr_en;
  logic [31:0] s_mem_address;
  logic [31:0] s_mem_wdata;
  logic [3:0]  s_mem_byte_enable;
  logic [31:0] s_mem_rdata = '0;
  logic        s_mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_error(resp_error),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut32 (
    .clock(clock), .reset(reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_write(s_req_write), .req_funct3(s_req_funct3),
    .req_address(s_req_address), .req_wdata(s_req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
    .resp_misaligned(s_resp_misaligned), .resp_error(s_resp_error),
    .mem_rd_en(s_mem_rd_en), .mem_wr_en(s_mem_wr_en),
    .mem_address(s_mem_address), .mem_wdata(s_mem_wdata),
    .mem_byte_enable(s_mem_byte_enable),
    .mem_rdata(s_mem_rdata), .mem_ack(s_mem_ack)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_address = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs ready=%b valid=%b exp 1/0", req_ready, resp_valid);
    end
    checks++;
    if ({mem_rd_en, mem_wr_en, mem_address, mem_wdata, mem_byte_enable,
         resp_rdata, resp_misaligned, resp_error} !== '0) begin
      failures++;
      $display("FAIL reset_outs addr=%h wdata=%h be=%h exp all 0",
               mem_address, mem_wdata, mem_byte_enable);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    issue(1'b0, 3'b000, 64'h1003, '0);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL lb_en rd=%b wr=%b ready=%b exp 1/0/0", mem_rd_en, mem_wr_en, req_ready);
    end
    checks++;
    if (mem_address !== 64'h1000 || mem_byte_enable !== 8'b0000_1000) begin
      failures++;
      $display("FAIL lb_lane addr=%h be=%b exp 1000/00001000", mem_address, mem_byte_enable);
    end
    mem_rdata = 64'h0000_0000_8000_0000;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL lb_resp valid=%b rdata=%h rd=%b exp 1/ffffffffffffff80/0",
               resp_valid, resp_rdata, mem_rd_en);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL lb_end valid=%b ready=%b exp 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_sh();
    issue(1'b1, 3'b001, 64'h2006, 64'h1234_ABCD);
    checks++;
    if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_address !== 64'h2000) begin
      failures++;
      $display("FAIL sh_en wr=%b rd=%b addr=%h exp 1/0/2000", mem_wr_en, mem_rd_en, mem_address);
    end
    checks++;
    if (mem_byte_enable !== 8'b1100_0000 || mem_wdata !== 64'hABCD_0000_0000_0000) begin
      failures++;
      $display("FAIL sh_lane be=%b wdata=%h exp 11000000/abcd000000000000",
               mem_byte_enable, mem_wdata);
    end
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== '0 || mem_wr_en !== 1'b0 || resp_error !== 1'b0) begin
      failures++;
      $display("FAIL sh_resp valid=%b rdata=%h wr=%b err=%b exp 1/0/0/0",
               resp_valid, resp_rdata, mem_wr_en, resp_error);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // Misaligned LW with a second request (LBU) held pending through DONE
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 64'h3002;
    tick();
    req_funct3 = 3'b100; req_address = 64'h1003;
    checks++;
    if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1 || resp_error !== 1'b0 ||
        mem_rd_en !== 1'b0 || req_ready !== 1'b0 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL lw_misal valid=%b mis=%b err=%b rd=%b ready=%b rdata=%h exp 1/1/0/0/0/0",
               resp_valid, resp_misaligned, resp_error, mem_rd_en, req_ready, resp_rdata);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || mem_rd_en !== 1'b0 || req_ready !== 1'b1 || resp_misaligned !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap valid=%b rd=%b ready=%b mis=%b exp 0/0/1/1",
               resp_valid, mem_rd_en, req_ready, resp_misaligned);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_address !== 64'h1000 || mem_byte_enable !== 8'h08) begin
      failures++;
      $display("FAIL lbu_acc rd=%b addr=%h be=%h exp 1/1000/08", mem_rd_en, mem_address, mem_byte_enable);
    end
    mem_rdata = 64'h0000_0000_8000_0000;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h80 || resp_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL lbu_resp valid=%b rdata=%h mis=%b exp 1/80/0", resp_valid, resp_rdata, resp_misaligned);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(1'b1, 3'b100, 64'h10, 64'h55);
    checks++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b1 || mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL sbu_illegal valid=%b err=%b wr=%b exp 1/1/0", resp_valid, resp_error, mem_wr_en);
    end
    tick();
    s_req_valid = 1'b1; s_req_funct3 = 3'b011; s_req_address = '0;
    tick();
    s_req_valid = 1'b0;
    checks++;
    if (s_resp_valid !== 1'b1 || s_resp_error !== 1'b1 || s_mem_rd_en !== 1'b0 ||
        s_resp_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL ld_x32 valid=%b err=%b rd=%b mis=%b exp 1/1/0/0",
               s_resp_valid, s_resp_error, s_mem_rd_en, s_resp_misaligned);
    end
    tick();
  endtask

  task automatic test_slow_ack();
    issue(1'b0, 3'b011, 64'h4000, '0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_rd_en !== 1'b1 || mem_address !== 64'h4000 || req_ready !== 1'b0 ||
          resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL ld_wait%0d rd=%b addr=%h ready=%b valid=%b exp 1/4000/0/0",
                 i, mem_rd_en, mem_address, req_ready, resp_valid);
      end
      tick();
    end
    mem_rdata = 64'h1122_3344_5566_7788;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL ld_resp valid=%b rdata=%h exp 1/1122334455667788", resp_valid, resp_rdata);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL ld_hold valid=%b rdata=%h exp 0/1122334455667788", resp_valid, resp_rdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack valid=%b ready=%b rd=%b exp 0/1/0", resp_valid, req_ready, mem_rd_en);
    end
  endtask

  task automatic test_reset_busy();
    issue(1'b0, 3'b011, 64'h5000, '0);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_rd_en !== 1'b0 ||
        mem_address !== '0 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL rst_busy ready=%b valid=%b rd=%b addr=%h exp 1/0/0/0",
               req_ready, resp_valid, mem_rd_en, mem_address);
    end
    reset = 1'b1;
    mem_rdata = 64'hFFFF_0000_FFFF_0000;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL late_ack valid=%b ready=%b rdata=%h exp 0/1/0", resp_valid, req_ready, resp_rdata);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL late_ack2 valid=%b exp 0", resp_valid);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    issue(1'b0, 3'b011, 64'h6000, '0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_rd_en !== 1'b1 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL to_wait%0d rd=%b valid=%b exp 1/0", i, mem_rd_en, resp_valid);
      end
      tick();
    end
    checks++;
    if (mem_rd_en !== 1'b0 || resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL to_resp rd=%b valid=%b err=%b rdata=%h exp 0/1/1/0",
               mem_rd_en, resp_valid, resp_error, resp_rdata);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_back_to_back();
    test_illegal();
    test_slow_ack();
    test_reset_busy();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
